// File: rtl/b27s_hex_seg.sv
// Purpose : hex digit (0-F) to 7-segment decoder with a registered side path.
// Latency : led is combinational (0 cycles); led_q and changed are 1 clk behind sw/blank.
// Backpr. : none; sw and blank are sampled on every rising clk edge.
//
// Ports:
//   clk     - system clock, all registers update on the rising edge
//   rst     - synchronous active-high reset
//   sw      - 4-bit hex digit to display
//   blank   - forces led_q to all-segments-off (led is unaffected)
//   led     - combinational segment pattern, bit0=a .. bit6=g
//   led_q   - registered segment pattern
//   changed - one-cycle pulse when the registered digit differs from the previous one
module b27s_hex_seg #(
    parameter logic ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       blank,
    output logic [6:0] led,
    output logic [6:0] led_q,
    output logic       changed
);

    // XOR mask applied to every segment output; all ones for common-anode parts.
    localparam logic [6:0] POLARITY = {7{ACTIVE_LOW}};
    // Segment value that leaves every segment dark in the chosen polarity.
    localparam logic [6:0] SEG_OFF  = POLARITY;

    logic [3:0] sw_q;
    logic [6:0] seg_hi;   // active-high glyph for sw

    // Active-high glyphs, pattern g..a. Every code maps to a defined glyph.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] g;
        g = 7'b0000000;
        unique case (v)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111011;
            4'hF: g = 7'b1110001;
        endcase
        return g;
    endfunction

    always_comb begin
        seg_hi = decode(sw);
        led    = seg_hi ^ POLARITY;
    end

    // Blanking only gates the registered pattern; sw_q and changed keep
    // tracking the digit so downstream logic sees value changes while dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q    <= 4'd0;
            led_q   <= SEG_OFF;
            changed <= 1'b0;
        end else begin
            sw_q    <= sw;
            changed <= (sw != sw_q);
            led_q   <= blank ? SEG_OFF : led;
        end
    end

endmodule

// File: tb/tb_b27s_hex_seg.sv
module tb_b27s_hex_seg;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       blank;
    logic [6:0] led0, led_q0, led1, led_q1;
    logic       chg0, chg1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference glyphs straight from the display table, pattern g..a.
    localparam logic [6:0] TBL [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111011, 7'b1110001
    };

    b27s_hex_seg #(.ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sw(sw), .blank(blank),
        .led(led0), .led_q(led_q0), .changed(chg0)
    );

    b27s_hex_seg #(.ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sw(sw), .blank(blank),
        .led(led1), .led_q(led_q1), .changed(chg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t sw=%h)", nm, act, exp, $time, sw);
        end
    endtask

    // Behavioural model: remember what was sampled at the last edge and
    // the digit held before it; outputs follow from those in active-high form.
    logic [3:0] m_prev_digit;   // digit held after the last edge (0 after reset)
    logic [6:0] m_led_q;
    logic       m_chg;

    always @(posedge clk) begin
        if (rst) begin
            m_prev_digit <= 4'd0;
            m_led_q      <= 7'd0;
            m_chg        <= 1'b0;
        end else begin
            m_chg        <= (sw != m_prev_digit);
            m_prev_digit <= sw;
            m_led_q      <= blank ? 7'd0 : TBL[sw];
        end
    end

    // Continuous compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("led_al0",     led0,         TBL[sw]);
            chk("led_al1",     led1,         ~TBL[sw]);
            chk("led_q_al0",   led_q0,       m_led_q);
            chk("led_q_al1",   led_q1,       ~m_led_q);
            chk("changed_al0", {6'd0, chg0}, {6'd0, m_chg});
            chk("changed_al1", {6'd0, chg1}, {6'd0, m_chg});
        end
    end

    // Advance one clock; inputs are re-driven just after the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        sw    = 4'd5;
        blank = 1'b0;

        // Reset held for two clocks with sw=5.
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_led",       led0,         7'b1101101);
        chk("rst_led_al1",   led1,         7'b0010010);
        chk("rst_led_q",     led_q0,       7'b0000000);
        chk("rst_led_q_al1", led_q1,       7'b1111111);
        chk("rst_changed",   {6'd0, chg0}, 7'd0);

        rst = 1'b0;
        cyc();
        chk("rel_led_q",   led_q0,       7'b1101101);
        chk("rel_changed", {6'd0, chg0}, 7'd1);

        // Combinational sweep: led must follow sw without any clock edge.
        for (int v = 0; v < 16; v++) begin
            sw = v[3:0];
            #1;
            chk("sweep_al0", led0, TBL[v]);
            chk("sweep_al1", led1, ~TBL[v]);
            if (v == 14) chk("sweep_E", led0, 7'b1111011);
            if (v == 15) chk("sweep_F", led0, 7'b1110001);
            if (v == 0)  chk("sweep0_al1", led1, 7'b1000000);
            if (v == 8)  chk("sweep8_al1", led1, 7'b0000000);
            #9;
        end
        cyc();

        // Digit 3 held, then 3 -> 7: one single-cycle change pulse.
        sw = 4'd3;
        cyc();
        cyc();
        chk("hold3_changed", {6'd0, chg0}, 7'd0);
        cyc();
        chk("hold3_led_q",   led_q0,       7'b1001111);
        chk("hold3_changed2",{6'd0, chg0}, 7'd0);
        sw = 4'd7;
        cyc();
        chk("to7_led_q",   led_q0,       7'b0000111);
        chk("to7_changed", {6'd0, chg0}, 7'd1);
        cyc();
        chk("to7_pulse_end", {6'd0, chg0}, 7'd0);

        // Blanking: only the registered pattern goes dark.
        sw    = 4'd8;
        blank = 1'b1;
        cyc();
        chk("blank_led",     led0,         7'b1111111);
        chk("blank_led_q",   led_q0,       7'b0000000);
        chk("blank_changed", {6'd0, chg0}, 7'd1);
        blank = 1'b0;
        cyc();
        chk("unblank_led_q", led_q0, 7'b1111111);

        // Reset mid-stream with sw=A.
        sw = 4'hA;
        cyc();
        chk("preA_led_q", led_q0, 7'b1110111);
        rst = 1'b1;
        cyc();
        chk("midrst_led_q",   led_q0,       7'b0000000);
        chk("midrst_changed", {6'd0, chg0}, 7'd0);
        chk("midrst_led",     led0,         7'b1110111);
        rst = 1'b0;
        cyc();
        chk("postrst_changed", {6'd0, chg0}, 7'd1);

        // Randomized traffic with occasional blank and reset.
        for (int i = 0; i < 600; i++) begin
            if (i % 40 < 6) sw = sw;
            else            sw = 4'($urandom_range(15));
            blank = ($urandom_range(3) == 0);
            rst   = ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0) begin
                rst   = 1'b1;
                blank = 1'b1;
            end
            cyc();
        end
        rst   = 1'b0;
        blank = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
